// File: rtl/uart_transmit_pkg.sv
// Shared UART definitions: transmitter state encoding and baud divisors at 25 MHz.
// The receiver imports the same package, so both ends agree on these values.
package uart_transmit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per serial bit with a 25 MHz system clock.
  localparam int BAUD_115200 = 217;
  localparam int BAUD_9600   = 2604;

endpackage

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out LSB first, framed by one start bit and one stop bit.
module uart_transmit
  import uart_transmit_pkg::*;
#(
  parameter int CYCLES_PER_BIT = BAUD_115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_serial_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  // One cycle before the last stop cycle, so the registered pulse lands in it.
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CYCLES_PER_BIT - 2);

  tx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             serial_r;
  logic             busy_r;
  logic             done_r;
  logic             bit_end_s;

  assign bit_end_s   = (cnt_r == CNT_LAST);
  assign o_tx_ready  = (state_r == IDLE);
  assign o_serial_tx = serial_r;
  assign o_tx_busy   = busy_r;
  assign o_tx_done   = done_r;

  // Frame sequencer: state, bit-period counter, data index, shifter and line outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      serial_r  <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
          serial_r  <= 1'b1;
          busy_r    <= 1'b0;
          if (i_tx_valid) begin
            // Line drops together with the state change so START lasts a full bit.
            shift_r  <= i_tx_byte;
            serial_r <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= START;
          end else begin
            shift_r  <= shift_r;
          end
        end

        START: begin
          if (bit_end_s) begin
            cnt_r    <= '0;
            serial_r <= shift_r[0];
            state_r  <= DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end_s) begin
            cnt_r     <= '0;
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              serial_r <= 1'b1;
              state_r  <= STOP;
            end else begin
              serial_r <= shift_r[1];
              shift_r  <= {1'b0, shift_r[7:1]};
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end_s) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            done_r <= (cnt_r == CNT_DONE);
          end
        end

        default: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
          serial_r  <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: one instance at 217 cycles/bit for framing,
// handshake and reset cases, one at 4 cycles/bit looped back into a bit sampler.
module tb_uart_transmit;

  localparam int CPB_A   = 217;
  localparam int FRAME_A = 10 * CPB_A;
  localparam int CPB_B   = 4;

  logic       clk;
  logic       rst_a, valid_a, ready_a, tx_a, busy_a, done_a;
  logic [7:0] byte_a;
  logic       rst_b, valid_b, ready_b, tx_b, busy_b, done_b;
  logic [7:0] byte_b;

  int vectors;
  int miscompares;

  uart_transmit #(.CYCLES_PER_BIT(CPB_A)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_tx_byte(byte_a), .i_tx_valid(valid_a),
    .o_tx_ready(ready_a), .o_serial_tx(tx_a), .o_tx_busy(busy_a), .o_tx_done(done_a)
  );

  uart_transmit #(.CYCLES_PER_BIT(CPB_B)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_tx_byte(byte_b), .i_tx_valid(valid_b),
    .o_tx_ready(ready_b), .o_serial_tx(tx_b), .o_tx_busy(busy_b), .o_tx_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level in cycle c (1-based) after acceptance of byte b.
  function automatic logic exp_line(input logic [7:0] b, input int c, input int cpb);
    int p;
    p = (c - 1) / cpb;
    if (p == 0) return 1'b0;
    else if (p <= 8) return b[p-1];
    else return 1'b1;
  endfunction

  task automatic accept_a(input logic [7:0] b, input logic hold);
    byte_a  = b;
    valid_a = 1'b1;
    tick();
    valid_a = hold;
  endtask

  task automatic idle_a(input string tag);
    chk({tag, "_line"},  {31'd0, tx_a},    32'd1);
    chk({tag, "_busy"},  {31'd0, busy_a},  32'd0);
    chk({tag, "_ready"}, {31'd0, ready_a}, 32'd1);
    chk({tag, "_done"},  {31'd0, done_a},  32'd0);
  endtask

  // Walk a whole frame cycle by cycle, optionally changing i_tx_byte at cycle chg_at.
  task automatic frame_a(input string tag, input logic [7:0] b, input int chg_at, input logic [7:0] chg_byte);
    for (int c = 1; c <= FRAME_A; c++) begin
      chk({tag, "_line"},  {31'd0, tx_a},    {31'd0, exp_line(b, c, CPB_A)});
      chk({tag, "_busy"},  {31'd0, busy_a},  32'd1);
      chk({tag, "_ready"}, {31'd0, ready_a}, 32'd0);
      chk({tag, "_done"},  {31'd0, done_a},  (c == FRAME_A) ? 32'd1 : 32'd0);
      if (c == chg_at) byte_a = chg_byte;
      tick();
    end
    idle_a({tag, "_gap"});
  endtask

  initial begin
    logic [7:0] sent;
    logic [7:0] rcvd;
    logic       seen_done;

    vectors     = 0;
    miscompares = 0;
    rst_a = 1'b1; valid_a = 1'b0; byte_a = 8'h00;
    rst_b = 1'b1; valid_b = 1'b0; byte_b = 8'h00;
    @(negedge clk);
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    idle_a("reset_a");
    chk("reset_b_line",  {31'd0, tx_b},    32'd1);
    chk("reset_b_ready", {31'd0, ready_b}, 32'd1);

    // 0x55: start, 1,0,1,0,1,0,1,0, stop; done in cycle 2170.
    accept_a(8'h55, 1'b0);
    frame_a("f55", 8'h55, 0, 8'h00);

    // Valid held high: 0xA5 then 0x3C back to back, byte changed mid-frame.
    accept_a(8'hA5, 1'b1);
    frame_a("fA5", 8'hA5, 1000, 8'h3C);
    tick();
    valid_a = 1'b0;
    frame_a("f3C", 8'h3C, 0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      tick();
      idle_a("after_pair");
    end

    // 0x00 with i_tx_byte switched to 0xFF mid-frame.
    accept_a(8'h00, 1'b0);
    frame_a("f00", 8'h00, 300, 8'hFF);
    tick();

    // Reset at cycle 1000 of a 0x80 frame: abort, no done, no resume.
    accept_a(8'h80, 1'b0);
    for (int c = 1; c <= 1000; c++) begin
      chk("f80_line", {31'd0, tx_a}, {31'd0, exp_line(8'h80, c, CPB_A)});
      if (c < 1000) tick();
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    idle_a("abort");
    for (int k = 0; k < 1500; k++) begin
      tick();
      idle_a("post_abort");
    end

    // Reset and valid together: the byte is dropped.
    byte_a  = 8'h00;
    valid_a = 1'b1;
    rst_a   = 1'b1;
    tick();
    rst_a   = 1'b0;
    valid_a = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      idle_a("rst_valid");
      tick();
    end

    // Loopback at 4 cycles/bit: find start edge, sample each bit in its middle.
    for (int n = 0; n < 256; n++) begin
      sent    = 8'($urandom_range(255, 0));
      byte_b  = sent;
      valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (tx_b == 1'b0) break;
        tick();
      end
      chk("lb_start_edge", {31'd0, tx_b}, 32'd0);
      tick();
      chk("lb_start_mid", {31'd0, tx_b}, 32'd0);
      rcvd = 8'h00;
      for (int i = 0; i < 8; i++) begin
        for (int k = 0; k < CPB_B; k++) tick();
        rcvd[i] = tx_b;
      end
      for (int k = 0; k < CPB_B; k++) tick();
      chk("lb_stop", {31'd0, tx_b}, 32'd1);
      chk("lb_byte", {24'd0, rcvd}, {24'd0, sent});
      seen_done = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (done_b) seen_done = 1'b1;
        if (ready_b) break;
        tick();
      end
      chk("lb_done", {31'd0, seen_done}, 32'd1);
      chk("lb_ready", {31'd0, ready_b}, 32'd1);
      chk("lb_busy", {31'd0, busy_b}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
